prefetch_queue: RTL and testbench

Parametrised instruction prefetch queue sitting between the fetch stage and the instruction memory path (MMU/icache response).
- Fetches word-aligned 32-bit lines ahead of the fetch stage into a DEPTH-entry circular buffer tagged with PCs.
- Extracts halfword-aligned 16/32-bit instructions, including 32-bit instructions straddling two words.
- Supports redirect flush with discard of an in-flight response, plus per-word bus-error propagation.

---
 rtl/prefetch_queue.sv | 202 ++++++++++++++++++++
 tb/tb_prefetch_queue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: word fetcher, DEPTH-entry PC-tagged buffer and 16/32-bit
// instruction aligner. Optional perf counters are enabled with `define PREFETCH_PERF_EN.
module prefetch_queue #(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       mem_req_o,
  output logic [XLEN-1:0]            mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [31:0]                mem_data_i,
  input  logic                       mem_err_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [31:0]                instr_o,
  output logic [XLEN-1:0]            instr_pc_o,
  output logic                       instr_is_comp_o,
  output logic                       instr_err_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]                stall_cnt_o,
  output logic [31:0]                flush_cnt_o
`endif
);

  localparam int unsigned     PW        = $clog2(DEPTH);
  localparam int unsigned     CW        = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] HALF_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic [31:0]     data_q [DEPTH];
  logic [DEPTH-1:0] err_q, err_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt_s;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d, addr_q, addr_d;
  logic            req_q, req_d, discard_q, discard_d;

  logic [31:0] head_s, instr_s;
  logic [15:0] lo_s;
  logic        off_s, comp_s, avail_s, err_s;
  logic        ack_s, push_s, fire_s, pop_s;

  // Aligner: pick the instruction starting at head_pc out of the head word(s).
  always_comb begin
    rd_nxt_s = rd_ptr_q + PW'(1);
    head_s   = data_q[rd_ptr_q];
    off_s    = head_pc_q[1];
    lo_s     = off_s ? head_s[31:16] : head_s[15:0];
    comp_s   = (lo_s[1:0] != 2'b11);
    if (comp_s || !off_s) begin
      avail_s = (count_q >= CW'(1));
    end else begin
      avail_s = (count_q >= CW'(2));
    end
    if (comp_s) begin
      instr_s = {16'h0000, lo_s};
      err_s   = err_q[rd_ptr_q];
    end else if (!off_s) begin
      instr_s = head_s;
      err_s   = err_q[rd_ptr_q];
    end else begin
      instr_s = {data_q[rd_nxt_s][15:0], lo_s};
      err_s   = err_q[rd_ptr_q] | err_q[rd_nxt_s];
    end
  end

  assign instr_valid_o   = avail_s & ~redirect_i;
  assign instr_o         = avail_s ? instr_s : 32'h0000_0000;
  assign instr_err_o     = avail_s & err_s;
  assign instr_is_comp_o = comp_s;
  assign instr_pc_o      = head_pc_q;
  assign mem_req_o       = req_q;
  assign mem_addr_o      = addr_q;
  assign count_o         = count_q;

  assign ack_s  = req_q & mem_ack_i;
  assign push_s = ack_s & ~discard_q & ~redirect_i;
  assign fire_s = instr_valid_o & instr_ready_i;
  // A 32-bit instruction always ends the head word; a compressed one only at offset 1.
  assign pop_s  = fire_s & (~comp_s | off_s);

  // Next-state for buffer pointers, PCs, request handshake and discard tracking.
  always_comb begin
    err_d      = err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    if (redirect_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      head_pc_d  = redirect_pc_i & HALF_MASK;
      fetch_pc_d = redirect_pc_i & WORD_MASK;
    end else begin
      if (push_s) begin
        err_d[wr_ptr_q] = mem_err_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
        fetch_pc_d      = fetch_pc_q + XLEN'(4);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (fire_s) begin
        head_pc_d = head_pc_q + (comp_s ? XLEN'(2) : XLEN'(4));
      end else begin
        head_pc_d = head_pc_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end

    if (redirect_i) begin
      discard_d = req_q & ~mem_ack_i;
    end else if (ack_s) begin
      discard_d = 1'b0;
    end else begin
      discard_d = discard_q;
    end

    // An issued request holds its address until acked, even across a redirect.
    addr_d = addr_q;
    if (req_q && !mem_ack_i) begin
      req_d = 1'b1;
    end else if (redirect_i) begin
      req_d = 1'b0;
    end else if (count_d < CW'(DEPTH)) begin
      req_d  = 1'b1;
      addr_d = fetch_pc_d;
    end else begin
      req_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC & WORD_MASK;
      head_pc_q  <= RESET_PC;
      addr_q     <= RESET_PC & WORD_MASK;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
    end
  end

  // Word storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      data_q[wr_ptr_q] <= mem_data_i;
    end
  end

`ifdef PREFETCH_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall and flush counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      if (instr_ready_i && !instr_valid_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue: a memory model feeds words and a reference
// decoder of the same memory image predicts the instruction stream.
module tb_prefetch_queue;

  logic        clk, rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o, mem_ack_i, mem_err_i;
  logic [31:0] mem_addr_o, mem_data_i;
  logic        instr_valid_o, instr_ready_i, instr_is_comp_o, instr_err_o;
  logic [31:0] instr_o, instr_pc_o;
  logic [2:0]  count_o;
`ifdef PREFETCH_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  prefetch_queue dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .mem_err_i(mem_err_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_is_comp_o(instr_is_comp_o), .instr_err_o(instr_err_o),
    .count_o(count_o)
`ifdef PREFETCH_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] img [128];
  int          n_cmp, n_bad;
  int          lat, wait_cnt, acks;
  logic        mem_on, ready_en, ready_force, redir_now, force_ack, stray_ack, chk_addr;
  logic [31:0] redir_pc, force_data, err_addr, exp_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] img_word(input logic [31:0] addr);
    int idx;
    idx = int'((addr - 32'h8000_0000) >> 2);
    if (idx >= 0 && idx < 128) return img[idx];
    return 32'h0000_0013;
  endfunction

  // Reference decode of n instructions from the memory image starting at pc.
  task automatic expect_n(input logic [31:0] pc_in, input int n);
    logic [31:0] pc, w, wn;
    logic [15:0] lo;
    exp_t e;
    pc = pc_in;
    for (int k = 0; k < n; k++) begin
      w  = img_word({pc[31:2], 2'b00});
      wn = img_word({pc[31:2], 2'b00} + 32'd4);
      lo = pc[1] ? w[31:16] : w[15:0];
      e.pc = pc;
      if (lo[1:0] != 2'b11) begin
        e.instr = {16'h0000, lo}; e.comp = 1'b1;
        e.err   = ({pc[31:2], 2'b00} == err_addr);
        pc = pc + 32'd2;
      end else if (!pc[1]) begin
        e.instr = w; e.comp = 1'b0;
        e.err   = ({pc[31:2], 2'b00} == err_addr);
        pc = pc + 32'd4;
      end else begin
        e.instr = {wn[15:0], lo}; e.comp = 1'b0;
        e.err   = ({pc[31:2], 2'b00} == err_addr) || (({pc[31:2], 2'b00} + 32'd4) == err_addr);
        pc = pc + 32'd4;
      end
      exp_q.push_back(e);
    end
  endtask

  // One clock: drive inputs on the falling edge, then score any consume.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    redirect_i    = redir_now;
    redirect_pc_i = redir_pc;
    redir_now     = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = 32'h0; mem_err_i = 1'b0;
    if (stray_ack) begin
      mem_ack_i = 1'b1; mem_data_i = 32'hBAD0_BAD0; stray_ack = 1'b0;
    end else if (mem_req_o && (mem_on || force_ack)) begin
      if (force_ack || wait_cnt >= lat) begin
        mem_ack_i  = 1'b1;
        mem_data_i = force_ack ? force_data : img_word(mem_addr_o);
        mem_err_i  = (mem_addr_o == err_addr);
        force_ack  = 1'b0;
        wait_cnt   = 0;
        acks++;
        if (chk_addr) begin
          n_cmp++;
          if (mem_addr_o !== exp_addr) begin
            n_bad++; $display("FAIL mem_addr: got %h want %h", mem_addr_o, exp_addr);
          end
          exp_addr = exp_addr + 32'd4;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    instr_ready_i = ready_force || (ready_en && exp_q.size() != 0);
    #1;
    if (instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_instr: got %h @%h want none", instr_o, instr_pc_o);
      end else begin
        e = exp_q.pop_front();
        n_cmp += 4;
        if (instr_o !== e.instr) begin
          n_bad++; $display("FAIL instr @%h: got %h want %h", e.pc, instr_o, e.instr);
        end
        if (instr_pc_o !== e.pc) begin
          n_bad++; $display("FAIL instr_pc: got %h want %h", instr_pc_o, e.pc);
        end
        if (instr_is_comp_o !== e.comp) begin
          n_bad++; $display("FAIL is_comp @%h: got %b want %b", e.pc, instr_is_comp_o, e.comp);
        end
        if (instr_err_o !== e.err) begin
          n_bad++; $display("FAIL instr_err @%h: got %b want %b", e.pc, instr_err_o, e.err);
        end
      end
    end
  endtask

  task automatic run_until_empty(input int max);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max) begin
      tick(); c++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL drain_timeout: %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; mem_ack_i = 1'b0; mem_data_i = 32'h0;
    mem_err_i = 1'b0; instr_ready_i = 1'b0;
    mem_on = 1'b1; lat = 0; wait_cnt = 0; acks = 0; ready_en = 1'b0; ready_force = 1'b0;
    redir_now = 1'b0; redir_pc = 32'h0; force_ack = 1'b0; stray_ack = 1'b0;
    chk_addr = 1'b0; err_addr = 32'h0; exp_addr = 32'h8000_0000;
    exp_q.delete();
    for (int i = 0; i < 128; i++) img[i] = {12'(i), 5'd0, 3'b000, 5'd1, 7'h13};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (4) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
    if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
    if (instr_o !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr_o); end
    if (count_o !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count_o); end
  endtask

  task automatic test_basic();
    do_reset();
    img[0] = 32'h0000_0013; img[1] = 32'h0010_0093;
    chk_addr = 1'b1; ready_en = 1'b1;
    expect_n(32'h8000_0000, 4);
    run_until_empty(40);
    chk_addr = 1'b0;
  endtask

  task automatic test_straddle();
    int gaps;
    do_reset();
    img[0] = 32'h0093_4501; img[1] = 32'h0000_0010;
    lat = 3; ready_en = 1'b1; gaps = 0;
    expect_n(32'h8000_0000, 3);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      tick();
      if (exp_q.size() == 2 && count_o == 3'd1 && instr_pc_o == 32'h8000_0002) begin
        gaps++; n_cmp++;
        if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL straddle_early: got %b want 0", instr_valid_o); end
      end
    end
    n_cmp++;
    if (gaps == 0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL straddle_run: gaps %0d left %0d want >0/0", gaps, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_full();
    do_reset();
    repeat (20) tick();
    n_cmp += 3;
    if (acks != 4) begin n_bad++; $display("FAIL full_acks: got %0d want 4", acks); end
    if (count_o !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", count_o); end
    if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL full_req: got %b want 0", mem_req_o); end
    stray_ack = 1'b1;
    tick(); tick();
    n_cmp++;
    if (count_o !== 3'd4) begin n_bad++; $display("FAIL stray_ack: got %0d want 4", count_o); end
    ready_en = 1'b1;
    expect_n(32'h8000_0000, 1);
    tick();
    tick();
    n_cmp += 3;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL full_consume: left %0d want 0", exp_q.size()); exp_q.delete(); end
    if (count_o !== 3'd3) begin n_bad++; $display("FAIL pop_count: got %0d want 3", count_o); end
    if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL pop_req: got %b want 1", mem_req_o); end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    mem_on = 1'b0; ready_en = 1'b1;
    for (int c = 0; c < 10 && !mem_req_o; c++) tick();
    redir_now = 1'b1; redir_pc = 32'h8000_0102;
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL redir_valid: got %b want 0", instr_valid_o); end
    tick();
    n_cmp += 2;
    if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL hold_req: got %b want 1", mem_req_o); end
    if (mem_addr_o !== 32'h8000_0000) begin n_bad++; $display("FAIL hold_addr: got %h want 80000000", mem_addr_o); end
    force_ack = 1'b1; force_data = 32'hDEAD_BEEF;
    tick();
    img[64] = 32'h1234_5678;
    expect_n(32'h8000_0102, 3);
    mem_on = 1'b1; lat = 1;
    tick();
    n_cmp += 3;
    if (count_o !== 3'd0) begin n_bad++; $display("FAIL discard_count: got %0d want 0", count_o); end
    if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL refetch_req: got %b want 1", mem_req_o); end
    if (mem_addr_o !== 32'h8000_0100) begin n_bad++; $display("FAIL refetch_addr: got %h want 80000100", mem_addr_o); end
    run_until_empty(60);
  endtask

  task automatic test_redirect_flush();
    do_reset();
    repeat (3) tick();
    redir_now = 1'b1; redir_pc = 32'h8000_0040; ready_force = 1'b1;
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", instr_valid_o); end
    ready_force = 1'b0;
    tick();
    n_cmp++;
    if (count_o !== 3'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", count_o); end
    ready_en = 1'b1;
    expect_n(32'h8000_0040, 4);
    run_until_empty(60);
  endtask

  task automatic test_bus_error();
    do_reset();
    img[0] = 32'h0000_0013; img[1] = 32'h0093_4501; img[2] = 32'h0000_0010;
    err_addr = 32'h8000_0008; lat = 1; ready_en = 1'b1;
    expect_n(32'h8000_0000, 6);
    run_until_empty(80);
  endtask

`ifdef PREFETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    mem_on = 1'b0;
    for (int k = 0; k < 3; k++) begin
      redir_now = 1'b1; redir_pc = 32'h8000_0010;
      tick();
    end
    tick();
    ready_force = 1'b1;
    repeat (5) tick();
    ready_force = 1'b0;
    tick(); tick();
    n_cmp += 2;
    if (flush_cnt_o !== 32'd3) begin n_bad++; $display("FAIL flush_cnt: got %0d want 3", flush_cnt_o); end
    if (stall_cnt_o !== 32'd5) begin n_bad++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt_o); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_straddle();
    test_full();
    test_redirect_discard();
    test_redirect_flush();
    test_bus_error();
`ifdef PREFETCH_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
